// File: rtl/seg_pkg.sv
// Shared types and constants for the paged 7-segment history scanner.
//   scan_state_t : page-advance mode (MANUAL = step button only, AUTO = timed dwell plus button)
//   SEG_BLANK    : active-low pattern with every segment off
//   NUM_PAGES    : pages in the 64-bit history register (16 bits each)
package seg_pkg;

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } scan_state_t;

  localparam logic [6:0]  SEG_BLANK = 7'h7F;
  localparam int unsigned NUM_PAGES = 4;

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex-nibble to 7-segment decoder.
//   hex : 4-bit value 0-F
//   seg : active-low segments {g,f,e,d,c,b,a}; b and d use the lowercase glyphs
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (hex)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
    endcase
  end

endmodule

// File: rtl/seg_page_scanner.sv
// Multiplexed 4-digit display of one 16-bit page out of a 4-page history register.
//   clk, clr : clock and synchronous active-high clear
//   regs     : history register, page p = regs[16p+15:16p], page 0 newest
//   load     : history shift strobe; its rising edges count valid pages (max 4)
//   step     : debounced button; rising edge selects the next page
//   auto_en  : 1 = AUTO (page advances every DWELL_SCANS frames), 0 = MANUAL
//   an       : active-low one-hot digit enable, an[3] leftmost
//   seg, dp  : active-low segments {g,f,e,d,c,b,a} and decimal point
//   page     : page index currently displayed
module seg_page_scanner
  import seg_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DWELL_SCANS = 1000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [63:0] regs,
  input  logic        load,
  input  logic        step,
  input  logic        auto_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  page
);

  localparam int unsigned DIV_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DWELL_W = (DWELL_SCANS > 1) ? $clog2(DWELL_SCANS) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(REFRESH_DIV - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_SCANS - 1);

  logic [DIV_W-1:0]   div_cnt;
  logic [1:0]         digit;
  logic [DWELL_W-1:0] dwell;
  logic [2:0]         fill;
  logic               load_q;
  logic               step_q;
  scan_state_t        state;
  scan_state_t        next_state;

  logic       tick;
  logic       frame_done;
  logic       load_rise;
  logic       step_rise;
  logic       dwell_expire;
  logic       advance;
  logic [1:0] page_next;
  logic [3:0] nibble;
  logic [6:0] glyph;

  always_comb begin
    tick         = (div_cnt == DIV_LAST);
    frame_done   = tick && (digit == 2'd3);
    load_rise    = load && !load_q;
    step_rise    = step && !step_q;
    next_state   = auto_en ? AUTO : MANUAL;
    dwell_expire = (state == AUTO) && frame_done && (dwell == DWELL_LAST);
    // A button edge coinciding with a dwell expiry is a single advance.
    advance      = step_rise || dwell_expire;
    // Wrap uses the fill count before any same-cycle load edge; fill <= 1 pins page at 0.
    page_next    = (({1'b0, page} + 3'd1) >= fill) ? '0 : page + 2'd1;
    // Bit offset 16*page + 4*digit.
    nibble       = regs[{page, digit, 2'b00} +: 4];
  end

  hex_to_seg u_hex_to_seg (
    .hex (nibble),
    .seg (glyph)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      div_cnt <= '0;
      digit   <= '0;
      dwell   <= '0;
      fill    <= '0;
      page    <= '0;
      load_q  <= 1'b0;
      step_q  <= 1'b0;
      state   <= MANUAL;
      an      <= '1;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
    end else begin
      load_q <= load;
      step_q <= step;
      state  <= next_state;

      if (tick) begin
        div_cnt <= '0;
        digit   <= digit + 2'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (load_rise && (fill != 3'(NUM_PAGES))) begin
        fill <= fill + 3'd1;
      end

      if (advance) begin
        page <= page_next;
      end

      if ((next_state != state) || advance) begin
        dwell <= '0;
      end else if ((state == AUTO) && frame_done) begin
        dwell <= dwell + 1'b1;
      end

      an <= ~(4'b0001 << digit);
      if (fill == '0) begin
        seg <= SEG_BLANK;
        dp  <= 1'b1;
      end else begin
        seg <= glyph;
        dp  <= (digit != page);
      end
    end
  end

endmodule

// File: tb/tb_seg_page_scanner.sv
// Self-checking bench for seg_page_scanner with REFRESH_DIV = 4, DWELL_SCANS = 2.
module tb_seg_page_scanner;

  localparam int unsigned DIV = 4;
  localparam int unsigned DW  = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [63:0] regs = '0;
  logic        load = 1'b0;
  logic        step = 1'b0;
  logic        auto_en = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  page;

  int unsigned checks = 0;
  int unsigned errors = 0;

  seg_page_scanner #(.REFRESH_DIV(DIV), .DWELL_SCANS(DW)) dut (
    .clk     (clk),
    .clr     (clr),
    .regs    (regs),
    .load    (load),
    .step    (step),
    .auto_en (auto_en),
    .an      (an),
    .seg     (seg),
    .dp      (dp),
    .page    (page)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic [1:0] page;
  } obs_t;

  obs_t expq[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Glyphs described by their lit segment letters, converted to active-low bits.
  function automatic logic [6:0] glyph_of(input logic [3:0] v);
    string s;
    logic [6:0] lit;
    case (v)
      4'h0: s = "abcdef";  4'h1: s = "bc";      4'h2: s = "abdeg";   4'h3: s = "abcdg";
      4'h4: s = "bcfg";    4'h5: s = "acdfg";   4'h6: s = "acdefg";  4'h7: s = "abc";
      4'h8: s = "abcdefg"; 4'h9: s = "abcdfg";  4'hA: s = "abcefg";  4'hB: s = "cdefg";
      4'hC: s = "adef";    4'hD: s = "bcdeg";   4'hE: s = "adefg";   default: s = "aefg";
    endcase
    lit = '0;
    for (int i = 0; i < s.len(); i++) begin
      lit[int'(s[i]) - 97] = 1'b1;
    end
    return ~lit;
  endfunction

  // Reference model: time since reset drives the scan position; pages, fill and
  // dwell are tracked as plain counts. Pushes what the DUT should show after each edge.
  initial begin
    int unsigned t, fill_n, pg, frames, d, idx;
    bit in_auto, load_prev, step_prev, frame_end, lr, sr, expire;
    obs_t e;
    t = 0; fill_n = 0; pg = 0; frames = 0;
    in_auto = 0; load_prev = 0; step_prev = 0;
    forever begin
      @(posedge clk);
      if (clr) begin
        t = 0; fill_n = 0; pg = 0; frames = 0;
        in_auto = 0; load_prev = 0; step_prev = 0;
        e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.page = 2'd0;
      end else begin
        d = (t / DIV) % 4;
        e.an = 4'hF;
        e.an[d] = 1'b0;
        if (fill_n == 0) begin
          e.seg = 7'h7F;
          e.dp  = 1'b1;
        end else begin
          idx   = pg * 16 + d * 4;
          e.seg = glyph_of(regs[idx +: 4]);
          e.dp  = (d != pg);
        end
        frame_end = ((t % (4 * DIV)) == (4 * DIV - 1));
        lr = load && !load_prev;
        sr = step && !step_prev;
        expire = in_auto && frame_end && (frames + 1 == DW);
        if (sr || expire) pg = (pg + 1 >= fill_n) ? 0 : pg + 1;
        if ((in_auto != auto_en) || sr || expire) frames = 0;
        else if (in_auto && frame_end) frames++;
        if (lr && fill_n < 4) fill_n++;
        in_auto = auto_en; load_prev = load; step_prev = step;
        t++;
        e.page = 2'(pg);
      end
      expq.push_back(e);
    end
  end

  // Monitor: outputs are registered, so every cycle presents a new observation.
  initial begin
    obs_t e;
    forever begin
      @(negedge clk);
      if (expq.size() == 0) begin
        chk("sb_underflow", 1, 0);
      end else begin
        e = expq.pop_front();
        chk("sb_an", an, e.an);
        chk("sb_seg", seg, e.seg);
        chk("sb_dp", dp, e.dp);
        chk("sb_page", page, e.page);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_load();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
  endtask

  // Counts negedges until page differs from its value on entry.
  task automatic wait_change(input int unsigned limit, output int unsigned n);
    logic [1:0] prev;
    prev = page;
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if (page != prev) return;
    end
    n = limit + 1;
  endtask

  initial begin
    int unsigned n;
    bit found;
    logic [1:0] exp_seq[4];
    logic [1:0] exp_auto[4];

    // Reset held for 3 cycles
    repeat (3) begin
      @(negedge clk);
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_page", page, 2'd0);
    end
    clr = 1'b0;
    found = 0;
    for (int i = 0; i < 5 && !found; i++) begin
      @(negedge clk);
      if (an == 4'hE) found = 1;
    end
    chk("rst_an_E_within_5", found, 1);

    // Blank while no page is valid
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("blank_seg", seg, 7'h7F);
    end
    regs[15:0] = 16'h1234;
    @(negedge clk);
    pulse_load();
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b0111) found = 1;
    end
    chk("digit3_found", found, 1);
    chk("digit3_seg_1", seg, 7'h79);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an == 4'b1110) found = 1;
    end
    chk("digit0_found", found, 1);
    chk("digit0_seg_4", seg, 7'h19);

    // Manual wrap with fill = 3
    regs = {$urandom, $urandom};
    pulse_load();
    pulse_load();
    chk("manual_start_page", page, 2'd0);
    exp_seq = '{2'd1, 2'd2, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      step = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("manual_step_page", page, exp_seq[i]);
      step = 1'b0;
      @(negedge clk);
    end
    step = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("hold_first_advance", page, 2'd2);
    repeat (9) @(negedge clk);
    chk("hold_single_advance", page, 2'd2);
    step = 1'b0;
    @(negedge clk);

    // Auto dwell with fill = 4, starting from page 0
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (4) pulse_load();
    chk("auto_start_page", page, 2'd0);
    auto_en = 1'b1;
    wait_change(80, n);
    chk("auto_first_in_time", (n <= 80), 1);
    chk("auto_first_page", page, 2'd1);
    exp_auto = '{2'd2, 2'd3, 2'd0, 2'd1};
    for (int i = 0; i < 4; i++) begin
      wait_change(80, n);
      chk("auto_interval", n, 32);
      chk("auto_page", page, exp_auto[i]);
    end

    // Step edge on the same edge as a dwell expiry (page now 1, just advanced)
    repeat (31) @(negedge clk);
    step = 1'b1;
    @(negedge clk);
    chk("simul_single_advance", page, 2'd2);
    step = 1'b0;
    wait_change(80, n);
    chk("simul_next_interval", n, 32);
    chk("simul_next_page", page, 2'd3);

    // Mid-operation reset in AUTO while page = 2
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (page == 2'd2) found = 1;
    end
    chk("reach_page2", found, 1);
    clr = 1'b1;
    @(negedge clk);
    chk("midrst_page", page, 2'd0);
    chk("midrst_state", dut.state, seg_pkg::MANUAL);
    chk("midrst_fill", dut.fill, 3'd0);
    clr = 1'b0;

    // Randomized traffic, checked by the scoreboard
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(15) == 0) regs = {$urandom, $urandom};
      if ($urandom_range(7) == 0) load = ~load;
      if ($urandom_range(5) == 0) step = ~step;
      if ($urandom_range(99) == 0) auto_en = ~auto_en;
      clr = ($urandom_range(299) == 0);
    end
    clr = 1'b0;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_page_scanner.md
SEG_PAGE_SCANNER -- requirements
Module: seg_page_scanner

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clk cycles per digit-scan step.
REQ-002 Parameter DWELL_SCANS, default 1000: full 4-digit scan frames per page in AUTO mode.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 clr  input  1  synchronous, active-high reset.
REQ-005 regs  input  64  history register contents; page p = regs[16p+15:16p], page 0 newest.
REQ-006 load  input  1  level strobe that shifts the history register; used here only to count valid pages.
REQ-007 step  input  1  debounced button level; its rising edge requests the next page.
REQ-008 auto_en  input  1  1 selects AUTO mode, 0 selects MANUAL mode.
REQ-009 an  output  4  active-low one-hot digit enable; an[3] is the leftmost digit.
REQ-010 seg  output  7  active-low segments {g,f,e,d,c,b,a} for the enabled digit.
REQ-011 dp  output  1  active-low decimal point.
REQ-012 page  output  2  index of the page currently displayed.

Function
REQ-013 The scan divider shall count 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the digit index (0..3) increments mod 4.
REQ-014 Digit index d shall show nibble regs[16*page+4d+3 : 16*page+4d] on an[d]; an, seg and dp are registered, so they change exactly 1 cycle after the digit index changes.
REQ-015 The fill counter shall increment on each rising edge of load (0->1 sampled on consecutive clocks) and saturate at 4.
REQ-016 If fill = 0, seg shall be 7'h7F (blank) and dp shall be 1 for every digit; an keeps scanning.
REQ-017 dp shall be 0 only when d equals page, marking the page position; otherwise 1.
REQ-018 The FSM shall have states MANUAL and AUTO, with next state equal to auto_en each cycle; any state change clears the dwell counter.
REQ-019 In MANUAL, a rising edge of step shall advance page by 1.
REQ-020 In AUTO, the dwell counter shall count completed scan frames (d wrapping 3->0); on reaching DWELL_SCANS it clears and advances page by 1.
REQ-021 A step edge in AUTO shall advance page and clear the dwell counter.
REQ-022 Page advance shall wrap to 0 when page+1 >= fill.
REQ-023 With fill <= 1, page shall stay 0.
REQ-024 A step edge and a dwell expiry in the same cycle shall produce exactly one advance.
REQ-025 A load edge while page is non-zero shall leave page unchanged, because data shifts under a fixed index.
REQ-026 Hex nibbles 0-F shall decode to the standard 7-segment glyphs, with lowercase b and d.

Reset
REQ-027 While clr = 1, the following shall be cleared: divider, digit index, dwell counter, fill, page = 0, and the edge-detect registers; state = MANUAL; an = 4'hF, seg = 7'h7F, dp = 1.
REQ-028 clr shall take priority over load, step and all counter events in the same cycle; operation resumes from the reset state on the first cycle after clr falls.

Structure
REQ-029 Package seg_pkg shall hold the state enum (MANUAL, AUTO), the constant SEG_BLANK = 7'h7F and the constant NUM_PAGES = 4.
REQ-030 Decoding shall be a sub-module, hex_to_seg, with a 4-bit input and a 7-bit active-low output, purely combinational.

Verification
All scenarios use REFRESH_DIV = 4 and DWELL_SCANS = 2.
REQ-031 Reset: assert clr for 3 cycles, then release; require an = F, seg = 7F, dp = 1 and page = 0 during reset, then an = E within 5 cycles.
REQ-032 Fill/blank: with no load, require seg = 7F on all digits; then pulse load with regs[15:0] = 16'h1234 and require that digit 3 shows 1 (7'h79) and digit 0 shows 4 (7'h19).
REQ-033 Manual wrap: with fill = 3, apply 4 step edges and require page sequence 1, 2, 0, 1; holding step high for 10 cycles shall cause only one advance.
REQ-034 Auto dwell: with fill = 4 and auto_en = 1, require page to advance every 32 clk cycles through 0, 1, 2, 3, 0.
REQ-035 Simultaneous events: a step edge in the same cycle as a dwell expiry shall advance page by 1 only, and the next advance shall occur 32 cycles later.
REQ-036 Mid-operation reset: asserting clr while page = 2 in AUTO shall give page = 0, state MANUAL and fill = 0 on the next cycle.
